fifo_frame_writer: RTL and testbench
====================================

# fifo_frame_writer

Write-domain producer for the dual-clock FIFO's write port, clocked by `write_clk`. It accepts a frame command (length) and a payload stream from local logic. It emits one header word followed by exactly that many payload words into the FIFO, throttled word-by-word by the FIFO `full` flag. The read-domain consumer uses the header to delimit frames.

## Interface
- `DATA_WIDTH`, 8: FIFO word width. It is also the width of the header and of `cmd_len`.
- `COUNT_WIDTH`, 16: width of the completed-frame counter.
- `write_clk` input 1: write-domain clock. All logic is on its rising edge.
- `write_reset_n` input 1: reset, asynchronous, active-low; clock `write_clk`.
- `cmd_valid` input 1: frame command offered.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_len` input DATA_WIDTH: payload length minus one (0 means 1 word, 2^DATA_WIDTH−1 means 2^DATA_WIDTH words).
- `in_valid` input 1: payload word offered.
- `in_ready` output 1: payload word accepted when `in_valid && in_ready`.
- `in_data` input DATA_WIDTH: payload word.
- `in_last` input 1: upstream marks its final word. Used for checking only.
- `full` input 1: FIFO full flag, same domain, combinational from the FIFO.
- `write_en` output 1: FIFO write strobe.
- `write_data` output DATA_WIDTH: FIFO write data.
- `busy` output 1: a frame is in progress (state is not IDLE).
- `len_error` output 1: sticky framing mismatch.
- `frame_count` output COUNT_WIDTH: completed frames, wraps modulo 2^COUNT_WIDTH.

## Operation
- **States**
  - IDLE: no frame in progress.
  - HDR: header word pending.
  - DATA: payload words pending.
- **IDLE**
  - `cmd_ready`=1.
  - On command handshake: latch `cmd_len` into `len_q`, clear `remaining` to `cmd_len`, go to HDR.
- **HDR**
  - `write_data`=`len_q`, `write_en`=`!full`.
  - On a write (`write_en`=1): go to DATA.
  - While `full`=1: stay in HDR, no write.
- **DATA**
  - `in_ready`=`!full`, `write_en`=`in_valid && !full`, `write_data`=`in_data` (pass-through).
  - On each accepted word:
    - If `remaining`==0: `frame_count`+1 and go to IDLE.
    - Otherwise: `remaining`−1.
- **Framing check**, on each accepted payload word:
  - Mismatch condition: `in_last` ≠ (`remaining`==0).
  - On mismatch: set `len_error`. It stays set until reset.
  - The header governs frame length. An early `in_last` does not end the frame; a missing `in_last` does not extend it.
- **Combinational outputs**
  - `cmd_ready`, `in_ready`, `write_en` and `write_data` decode state, `full` and `in_valid` combinationally.
  - `cmd_ready` and `in_ready` do not depend on `cmd_valid`/`in_valid`.
- **Idle defaults**: in IDLE, `write_en`=0, `in_ready`=0 and `write_data`=0.
- **Never write into a full FIFO**: `write_en` must never be 1 while `full`=1.
- **Width rules**: `remaining` is DATA_WIDTH bits and never underflows; the transition to IDLE occurs at 0.

## Timing
- **Reset**
  - Asynchronous; all registers clear.
  - State=IDLE, `len_error`=0, `frame_count`=0, `busy`=0, `write_en`=0, `write_data`=0, `in_ready`=0.
  - `cmd_ready` is forced 0 while `write_reset_n` is low, and is 1 from the first cycle after deassertion.
- **Reset mid-frame**: the frame is abandoned. Partial FIFO contents are the FIFO's concern because they share the reset. No header or data write follows.
- **Command latency**: command accepted in cycle T → header written in cycle T+1 if `full`=0.
- **Payload latency**: the first payload write is possible in cycle T+2.
- **Frame length**: a frame of N payload words occupies N+1 write cycles minimum.
- **Back-to-back frames**: the last payload write is in cycle L → IDLE in L+1, when `cmd_ready`=1. The next header can be written in L+2 at the earliest, so there is one bubble between frames.
- **Full throttling**: `full` rising stalls writes in the same cycle. Throughput is one word per cycle when `full`=0 and `in_valid`=1.

## Test plan
1. **Single-word frame.** After reset, issue a command with `cmd_len`=0, then payload 0xA5 with `in_last`=1 and `full`=0.
   - Required: two writes, 0x00 then 0xA5, in consecutive cycles.
   - Then `frame_count`=1, `busy`=0, `len_error`=0.
2. **Four-word frame with full stall.** `cmd_len`=3, payload 0x11, 0x22, 0x33, 0x44 (`in_last` on 0x44). Hold `full`=1 for 3 cycles before 0x33.
   - Required: write sequence 0x03, 0x11, 0x22, 0x33, 0x44.
   - No `write_en` during the stall; `in_ready`=0 during the stall.
3. **Back-to-back frames.** Two `cmd_len`=1 frames with `cmd_valid` held high.
   - Required: exactly one idle cycle between the last payload write of frame 1 and header 0x01 of frame 2.
   - Then `frame_count`=2.
4. **Framing errors.**
   - Early case: `cmd_len`=2 with `in_last` on word 1. Required: `len_error`=1 after that word, and 3 payload words still written.
   - Late case: a separate run with `in_last`=0 on the final word. Required: `len_error` also sets.
5. **Reset mid-frame.** Assert `write_reset_n` low during DATA after 2 of 5 words.
   - Required: `write_en`=0 immediately, state IDLE, `frame_count`=0.
   - The next command produces a clean header.
6. **Counter wrap.** Set COUNT_WIDTH=4 and run 17 single-word frames.
   - Required: `frame_count` reads 1.

Source files
------------

// File: rtl/fifo_frame_writer.sv
// ============================================================================
// fifo_frame_writer
// ----------------------------------------------------------------------------
// Write-domain producer for the dual-clock FIFO. It accepts a frame command
// (payload length minus one) and a payload stream. It then writes one header
// word followed by exactly that many payload words. Each write is throttled by
// the FIFO full flag. The header word carries the length, and the read side
// uses it to delimit frames.
//
// Parameters
//   DATA_WIDTH   FIFO word width; also the header and cmd_len width
//   COUNT_WIDTH  completed-frame counter width (wraps)
//
// Ports
//   write_clk      write-domain clock, rising edge
//   write_reset_n  asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len   frame command handshake
//   in_valid/in_ready/in_data     payload stream handshake
//   in_last        upstream end-of-frame marker (checked, not obeyed)
//   full           FIFO full flag (combinational from the FIFO)
//   write_en       FIFO write strobe, never asserted while full
//   write_data     FIFO write data (header or pass-through payload)
//   busy           a frame is in progress
//   len_error      sticky in_last / header length mismatch
//   frame_count    completed frames, modulo 2^COUNT_WIDTH
// ============================================================================
module fifo_frame_writer #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   write_clk,
   input  logic                   write_reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [DATA_WIDTH-1:0]  cmd_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   input  logic                   full,
   output logic                   write_en,
   output logic [DATA_WIDTH-1:0]  write_data,
   output logic                   busy,
   output logic                   len_error,
   output logic [COUNT_WIDTH-1:0] frame_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] len_q;
   logic [DATA_WIDTH-1:0] remaining;
   logic                  cmd_fire;
   logic                  word_fire;
   logic                  last_word;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign word_fire = (state == DATA) && in_valid && !full;
   // remaining counts down to zero and stops there; zero marks the final word.
   assign last_word = (remaining == '0);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples pre-edge values, whatever order the blocks run in.
   always_ff @(posedge write_clk or negedge write_reset_n) begin
      if (!write_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cmd_fire)               state_nxt = HDR;
         HDR:  if (!full)                  state_nxt = DATA;
         DATA: if (word_fire && last_word) state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode
   // -------------------------------------------------------------------------
   always_comb begin
      cmd_ready  = 1'b0;
      in_ready   = 1'b0;
      write_en   = 1'b0;
      write_data = '0;
      case (state)
         // The state register already reads IDLE during reset. Gate with the
         // reset so that no command is accepted while reset is held low.
         IDLE: cmd_ready = write_reset_n;
         HDR: begin
            write_en   = !full;
            write_data = len_q;
         end
         DATA: begin
            in_ready   = !full;
            write_en   = in_valid && !full;
            write_data = in_data;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   // -------------------------------------------------------------------------
   // Length tracking, frame counter and framing check
   // -------------------------------------------------------------------------
   always_ff @(posedge write_clk or negedge write_reset_n) begin
      if (!write_reset_n) begin
         len_q       <= '0;
         remaining   <= '0;
         len_error   <= 1'b0;
         frame_count <= '0;
      end else begin
         if (cmd_fire) begin
            len_q     <= cmd_len;
            remaining <= cmd_len;
         end
         if (word_fire) begin
            if (last_word) begin
               frame_count <= frame_count + COUNT_WIDTH'(1);
            end else begin
               remaining <= remaining - DATA_WIDTH'(1);
            end
            // The header alone sets the frame length. in_last is only checked
            // against it, and a disagreement is recorded until reset.
            if (in_last != last_word) begin
               len_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// ============================================================================
// tb_fifo_frame_writer
// ----------------------------------------------------------------------------
// Directed bench for fifo_frame_writer. One instance has the default counter
// width. A second instance with COUNT_WIDTH=4 shares all inputs, so its counter
// can be checked for wrap. A negedge monitor records every FIFO write (data and
// cycle number) and counts any write made while full is high.
// ============================================================================
module tb_fifo_frame_writer;

   localparam int DW = 8;

   logic          write_clk = 1'b0;
   logic          write_reset_n;
   logic          cmd_valid;
   logic [DW-1:0] cmd_len;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          full;

   logic          cmd_ready,  in_ready,  write_en,  busy,  len_error;
   logic [DW-1:0] write_data;
   logic [15:0]   frame_count;

   logic          w_cmd_ready, w_in_ready, w_write_en, w_busy, w_len_error;
   logic [DW-1:0] w_write_data;
   logic [3:0]    w_frame_count;

   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   int            full_writes = 0;
   logic [DW-1:0] wq[$];
   int            wcyc[$];
   logic [DW-1:0] eq[$];

   fifo_frame_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) dut (
      .write_clk     (write_clk),
      .write_reset_n (write_reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_len       (cmd_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .full          (full),
      .write_en      (write_en),
      .write_data    (write_data),
      .busy          (busy),
      .len_error     (len_error),
      .frame_count   (frame_count)
   );

   fifo_frame_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut_w (
      .write_clk     (write_clk),
      .write_reset_n (write_reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (w_cmd_ready),
      .cmd_len       (cmd_len),
      .in_valid      (in_valid),
      .in_ready      (w_in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .full          (full),
      .write_en      (w_write_en),
      .write_data    (w_write_data),
      .busy          (w_busy),
      .len_error     (w_len_error),
      .frame_count   (w_frame_count)
   );

   always #5 write_clk = ~write_clk;

   always @(posedge write_clk) cyc++;

   always @(negedge write_clk) begin
      if (write_en) begin
         wq.push_back(write_data);
         wcyc.push_back(cyc);
         if (full) full_writes++;
      end
   end

   task automatic tick();
      @(posedge write_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compares the recorded writes with the expected queue, then clears both.
   task automatic compare_writes(input string tag);
      check({tag, " write count"}, wq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++) begin
         if (i < wq.size()) check($sformatf("%s write[%0d]", tag, i), wq[i], eq[i]);
      end
      wq.delete();
      wcyc.delete();
      eq.delete();
   endtask

   task automatic apply_reset(input string tag);
      write_reset_n = 1'b0;
      #1;
      check({tag, " cmd_ready"},   cmd_ready,   0);
      check({tag, " write_en"},    write_en,    0);
      check({tag, " write_data"},  write_data,  0);
      check({tag, " in_ready"},    in_ready,    0);
      check({tag, " busy"},        busy,        0);
      check({tag, " len_error"},   len_error,   0);
      check({tag, " frame_count"}, frame_count, 0);
      tick();
      tick();
      write_reset_n = 1'b1;
      #1;
      check({tag, " cmd_ready after release"}, cmd_ready, 1);
   endtask

   initial begin
      write_reset_n = 1'b0;
      cmd_valid     = 1'b0;
      cmd_len       = '0;
      in_valid      = 1'b0;
      in_data       = '0;
      in_last       = 1'b0;
      full          = 1'b0;

      apply_reset("reset");

      // ---- 1: single-word frame ---------------------------------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'd0; #1;
      check("t1 idle write_en", write_en, 0);
      tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1; #1;
      check("t1 hdr write_data", write_data, 8'h00);
      check("t1 hdr in_ready", in_ready, 0);
      check("t1 busy", busy, 1);
      tick(); #1;
      check("t1 data write_en", write_en, 1);
      tick(); in_valid = 1'b0; #1;
      check("t1 busy after", busy, 0);
      check("t1 frame_count", frame_count, 1);
      check("t1 len_error", len_error, 0);
      check("t1 write spacing", (wcyc.size() == 2) ? (wcyc[1] - wcyc[0]) : -1, 1);
      eq = '{8'h00, 8'hA5};
      compare_writes("t1");

      // ---- 2: four-word frame, full stall before 0x33 -----------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'd3;
      tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
      tick();
      tick(); in_data = 8'h22;
      tick(); in_data = 8'h33; full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t2 stall%0d write_en", i), write_en, 0);
         check($sformatf("t2 stall%0d in_ready", i), in_ready, 0);
         if (i < 2) tick();
      end
      tick(); full = 1'b0;
      tick(); in_data = 8'h44; in_last = 1'b1;
      tick(); in_valid = 1'b0; #1;
      check("t2 busy after", busy, 0);
      check("t2 frame_count", frame_count, 2);
      check("t2 len_error", len_error, 0);
      eq = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
      compare_writes("t2");

      // ---- 3: back-to-back frames with cmd_valid held -----------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'd1;
      in_valid = 1'b1; in_data = 8'hB1; in_last = 1'b0;
      tick();
      tick();
      tick(); in_data = 8'hB2; in_last = 1'b1;
      tick(); in_data = 8'hC1; in_last = 1'b0; #1;
      check("t3 bubble write_en", write_en, 0);
      check("t3 bubble cmd_ready", cmd_ready, 1);
      tick(); cmd_valid = 1'b0;
      tick();
      tick(); in_data = 8'hC2; in_last = 1'b1;
      tick(); in_valid = 1'b0; #1;
      check("t3 frame_count", frame_count, 4);
      check("t3 gap", (wcyc.size() == 6) ? (wcyc[3] - wcyc[2]) : -1, 2);
      eq = '{8'h01, 8'hB1, 8'hB2, 8'h01, 8'hC1, 8'hC2};
      compare_writes("t3");

      // ---- 4a: early in_last ------------------------------------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'd2;
      tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'hD1; in_last = 1'b1;
      tick();
      tick(); in_data = 8'hD2; in_last = 1'b0; #1;
      check("t4a len_error after early last", len_error, 1);
      check("t4a still busy", busy, 1);
      tick(); in_data = 8'hD3; in_last = 1'b1;
      tick(); in_valid = 1'b0; #1;
      check("t4a frame_count", frame_count, 5);
      check("t4a len_error sticky", len_error, 1);
      eq = '{8'h02, 8'hD1, 8'hD2, 8'hD3};
      compare_writes("t4a");

      // ---- 4b: missing in_last, fresh run ------------------------------------
      apply_reset("t4b reset");
      tick(); cmd_valid = 1'b1; cmd_len = 8'd1;
      tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'hE1; in_last = 1'b0;
      tick();
      tick(); in_data = 8'hE2; #1;
      check("t4b len_error before final", len_error, 0);
      tick(); in_valid = 1'b0; #1;
      check("t4b len_error after final", len_error, 1);
      check("t4b frame_count", frame_count, 1);
      check("t4b busy", busy, 0);
      eq = '{8'h01, 8'hE1, 8'hE2};
      compare_writes("t4b");

      // ---- 5: reset mid-frame -----------------------------------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'd4;
      tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'hF1; in_last = 1'b0;
      tick();
      tick(); in_data = 8'hF2;
      tick(); in_data = 8'hF3; #1;
      check("t5 pre-reset write_en", write_en, 1);
      apply_reset("t5 reset");
      in_valid = 1'b0;
      eq = '{8'h04, 8'hF1, 8'hF2};
      compare_writes("t5 partial");
      tick(); cmd_valid = 1'b1; cmd_len = 8'd0;
      tick(); cmd_valid = 1'b0; full = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; #1;
      check("t5 hdr held while full", write_en, 0);
      check("t5 hdr busy", busy, 1);
      tick(); full = 1'b0; #1;
      check("t5 hdr write_en", write_en, 1);
      tick();
      tick(); in_valid = 1'b0; #1;
      check("t5 frame_count", frame_count, 1);
      check("t5 len_error", len_error, 0);
      eq = '{8'h00, 8'h5A};
      compare_writes("t5 clean");

      // ---- 6: counter wrap with COUNT_WIDTH=4 --------------------------------
      apply_reset("t6 reset");
      for (int i = 0; i < 17; i++) begin
         tick(); cmd_valid = 1'b1; cmd_len = 8'd0;
         tick(); cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'(i); in_last = 1'b1;
         tick();
      end
      tick(); in_valid = 1'b0; #1;
      check("t6 wrap frame_count", w_frame_count, 1);
      check("t6 wide frame_count", frame_count, 17);
      check("t6 write count", wq.size(), 34);
      wq.delete();
      wcyc.delete();

      // ---- maximum-length frame (cmd_len all ones) -----------------------------
      tick(); cmd_valid = 1'b1; cmd_len = 8'hFF;
      tick(); cmd_valid = 1'b0; in_valid = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(255 - i);
         in_last = (i == 255);
         tick();
      end
      in_valid = 1'b0; #1;
      check("max busy", busy, 0);
      check("max frame_count", frame_count, 18);
      check("max wrap frame_count", w_frame_count, 2);
      check("max len_error", len_error, 0);
      eq.push_back(8'hFF);
      for (int i = 0; i < 256; i++) eq.push_back(8'(255 - i));
      compare_writes("max");

      check("writes while full", full_writes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
